lcd_i80_target: RTL and testbench
=================================

// Module: lcd_i80_target
// PURPOSE
//  Panel-side responder for the 8080-style parallel LCD bus (CS/RS/WR/RD/RST/DATA), clocked by HCLK.
//  Samples the bus asynchronously, captures each write strobe as a {RS,DATA} word into a FIFO and
//  drives read data back on RD strobes. Used as a display emulator and loopback target for the LCD bus.
// PARAMETERS
//  DEPTH     16  capture FIFO depth in words; power of two, >= 2
//  SYNC_LEN  2   synchronizer flops per bus input; >= 2
// PORTS
//  HCLK          in   1   clock
//  HRESETn       in   1   asynchronous active-low reset
//  LCD_CS        in   1   chip select, active low
//  LCD_RS        in   1   0 = command, 1 = data
//  LCD_WR        in   1   write strobe; word is taken on its rising edge
//  LCD_RD        in   1   read strobe, active low
//  LCD_RST       in   1   panel reset, active low; flushes FIFO
//  LCD_DATA_I    in   16  bus data from host
//  LCD_DATA_O    out  16  read-back data to host
//  LCD_DATA_OE   out  1   1 = drive LCD_DATA_O onto bus
//  rd_word       in   16  value returned on the next read strobe
//  word_valid    out  1   FIFO head valid
//  word_ready    in   1   consumer accepts head when word_valid & word_ready
//  word_is_data  out  1   RS of head word
//  word_data     out  16  DATA of head word
//  last_cmd      out  16  most recent word captured with RS=0
//  fifo_count    out  clog2(DEPTH)+1  words held
//  overflow      out  1   sticky: a word was dropped on full FIFO
//  drop_count    out  8   dropped words, saturates at 255
// BEHAVIOUR
//  Reset (HRESETn=0): FIFO empty, word_valid=0, word_is_data=0, word_data=0, last_cmd=0, fifo_count=0,
//   overflow=0, drop_count=0, LCD_DATA_OE=0, LCD_DATA_O=0; sync chains load CS=1,WR=1,RD=1,RST=1,RS=0,DATA=0.
//  Sync: CS,RS,WR,RD,RST,DATA each pass SYNC_LEN flops; one extra flop on WR and RD for edge detect.
//  Write capture: sync WR 0->1 while sync CS=0 -> push {RS,DATA} from last sync stage (same stage as WR).
//   Pin WR rise to word_valid: SYNC_LEN+1 HCLK edges (3 at default). WR edges with CS=1 are ignored.
//  Host must hold RS/DATA stable >= SYNC_LEN+1 HCLK around WR rise and keep WR high/low >= SYNC_LEN+1 HCLK.
//  RS=0 capture also updates last_cmd in the same cycle as the push, even if the FIFO drops the word.
//  FIFO: first-word-fall-through; head on word_* outputs while word_valid=1; pop on valid&ready.
//   Full, no pop: push dropped, overflow<=1, drop_count+1 (saturate 255). Full with pop same cycle:
//   push accepted, count unchanged. Empty: word_ready ignored. Pointers wrap modulo DEPTH.
//  Read response FSM: IDLE -> DRIVE on sync RD 1->0 with sync CS=0: latch rd_word into LCD_DATA_O,
//   LCD_DATA_OE<=1. DRIVE -> IDLE when sync RD=1 or sync CS=1: LCD_DATA_OE<=0, LCD_DATA_O held.
//   rd_word changes during DRIVE do not affect LCD_DATA_O. A WR capture during DRIVE is still taken.
//  Panel reset: sync RST=0 -> FIFO flushed (count 0, word_valid 0), FSM forced IDLE, OE=0, last_cmd=0;
//   overflow/drop_count kept (cleared only by HRESETn). No capture while sync RST=0.
//  HRESETn mid-transfer: everything returns to reset values; in-flight strobe edges are lost.
// TESTING
//  1 Reset, CS=0, RS=0 DATA=0x002C WR pulse -> after 3 HCLK word_valid=1, is_data=0, data=0x002C,
//    last_cmd=0x002C, fifo_count=1.
//  2 ready=0, 17 RS=1 writes 0x0001..0x0011 (DEPTH 16) -> count=16, overflow=1, drop_count=1;
//    drain -> 0x0001..0x0010 in order, valid=0 after 16th pop.
//  3 Full FIFO, ready=1 held while WR pulses -> pushes and pops overlap, count stays 16, drop_count unchanged.
//  4 rd_word=0x9341, CS=0, RD low 6 HCLK -> OE=1 within 3 HCLK of RD fall, LCD_DATA_O=0x9341;
//    rd_word->0x0000 mid-strobe keeps 0x9341; OE=0 within 3 HCLK of RD rise.
//  5 WR pulses with CS=1 -> no push; 3 words queued then LCD_RST=0 -> count=0, valid=0, last_cmd=0,
//    overflow unchanged.
//  6 Assert HRESETn=0 during RD-low DRIVE with 5 queued words -> OE=0, count=0, drop_count=0.

Source files
------------

// File: rtl/lcd_i80_if.sv
// 8080-style parallel LCD bus between a host (master) and a panel-side target (slave).
`timescale 1ns/1ps
interface lcd_i80_if;
    logic        LCD_CS;
    logic        LCD_RS;
    logic        LCD_WR;
    logic        LCD_RD;
    logic        LCD_RST;
    logic [15:0] LCD_DATA_I;
    logic [15:0] LCD_DATA_O;
    logic        LCD_DATA_OE;

    modport master (
        output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_DATA_I,
        input  LCD_DATA_O, LCD_DATA_OE
    );

    modport slave (
        input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_DATA_I,
        output LCD_DATA_O, LCD_DATA_OE
    );
endinterface

// File: rtl/lcd_i80_target.sv
// Panel-side i80 responder: synchronizes the bus, captures write strobes into a FWFT FIFO
// and answers read strobes with rd_word.
//
//  state | meaning
//  IDLE  | bus outputs released, waiting for a selected RD falling edge
//  DRIVE | LCD_DATA_O driven with the rd_word latched at the RD fall
`timescale 1ns/1ps
module lcd_i80_target #(
    parameter int DEPTH    = 16,
    parameter int SYNC_LEN = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    lcd_i80_if.slave                 bus,
    input  logic [15:0]              rd_word,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     word_is_data,
    output logic [15:0]              word_data,
    output logic [15:0]              last_cmd,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, DRIVE} rd_state_t;

    logic [SYNC_LEN-1:0] cs_sync, rs_sync, wr_sync, rd_sync, rst_sync;
    logic [15:0]         data_sync [SYNC_LEN];
    logic                wr_d, rd_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cs_sync  <= '1;
            wr_sync  <= '1;
            rd_sync  <= '1;
            rst_sync <= '1;
            rs_sync  <= '0;
            for (int i = 0; i < SYNC_LEN; i++) data_sync[i] <= '0;
            wr_d     <= 1'b1;
            rd_d     <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_LEN-2:0],  bus.LCD_CS};
            wr_sync  <= {wr_sync[SYNC_LEN-2:0],  bus.LCD_WR};
            rd_sync  <= {rd_sync[SYNC_LEN-2:0],  bus.LCD_RD};
            rst_sync <= {rst_sync[SYNC_LEN-2:0], bus.LCD_RST};
            rs_sync  <= {rs_sync[SYNC_LEN-2:0],  bus.LCD_RS};
            data_sync[0] <= bus.LCD_DATA_I;
            for (int i = 1; i < SYNC_LEN; i++) data_sync[i] <= data_sync[i-1];
            wr_d     <= wr_sync[SYNC_LEN-1];
            rd_d     <= rd_sync[SYNC_LEN-1];
        end
    end

    logic        cs_s, rs_s, wr_s, rd_s, rst_s;
    logic [15:0] data_s;
    assign cs_s   = cs_sync[SYNC_LEN-1];
    assign rs_s   = rs_sync[SYNC_LEN-1];
    assign wr_s   = wr_sync[SYNC_LEN-1];
    assign rd_s   = rd_sync[SYNC_LEN-1];
    assign rst_s  = rst_sync[SYNC_LEN-1];
    assign data_s = data_sync[SYNC_LEN-1];

    logic panel_rst, capture, rd_fall;
    assign panel_rst = ~rst_s;
    assign capture   = wr_s & ~wr_d & ~cs_s & rst_s;
    assign rd_fall   = ~rd_s & rd_d;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, pop, push_ok, drop;

    assign word_valid = (fifo_count != '0);
    assign full       = (fifo_count == (AW+1)'(DEPTH));
    assign pop        = word_valid & word_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = capture & (~full | pop);
    assign drop       = capture & full & ~pop;

    always_ff @(posedge HCLK) begin
        if (push_ok) mem[wptr] <= {rs_s, data_s};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else if (panel_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Drop statistics survive a panel reset; only HRESETn clears them.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)               last_cmd <= '0;
        else if (panel_rst)         last_cmd <= '0;
        else if (capture && !rs_s)  last_cmd <= data_s;
    end

    logic [16:0] head;
    assign head         = mem[rptr];
    assign word_is_data = word_valid & head[16];
    assign word_data    = word_valid ? head[15:0] : 16'h0000;

    rd_state_t   state_q, state_d;
    logic        load_rd;
    logic [15:0] data_o_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_rd = 1'b0;
        if (panel_rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_fall && !cs_s) begin
                        state_d = DRIVE;
                        load_rd = 1'b1;
                    end
                end
                DRIVE: begin
                    if (rd_s || cs_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     data_o_q <= '0;
        else if (load_rd) data_o_q <= rd_word;
    end

    assign bus.LCD_DATA_O  = data_o_q;
    assign bus.LCD_DATA_OE = (state_q == DRIVE);
endmodule

// File: tb/tb_lcd_i80_target.sv
// Directed bench for lcd_i80_target: write capture, FIFO full/overlap, read drive, panel and bus reset.
`timescale 1ns/1ps
module tb_lcd_i80_target;
    logic        HCLK;
    logic        HRESETn;
    logic [15:0] rd_word;
    logic        word_valid;
    logic        word_ready;
    logic        word_is_data;
    logic [15:0] word_data;
    logic [15:0] last_cmd;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_i80_if bus ();

    lcd_i80_target #(.DEPTH(16), .SYNC_LEN(2)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .bus          (bus),
        .rd_word      (rd_word),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_is_data (word_is_data),
        .word_data    (word_data),
        .last_cmd     (last_cmd),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // WR low for 4 cycles, then rise; returns 1ns after the edge that precedes the rise.
    task automatic bus_write(input logic cs, input logic rs, input logic [15:0] d);
        @(posedge HCLK); #1;
        bus.LCD_CS = cs; bus.LCD_RS = rs; bus.LCD_DATA_I = d; bus.LCD_WR = 1'b0;
        repeat (4) @(posedge HCLK);
        #1 bus.LCD_WR = 1'b1;
    endtask

    task automatic bus_write_settle(input logic cs, input logic rs, input logic [15:0] d);
        bus_write(cs, rs, d);
        repeat (4) @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", word_valid); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_checks++; if (word_data !== 16'h0 || word_is_data !== 1'b0) begin n_fail++; $display("FAIL reset_head got %h/%0b want 0000/0", word_data, word_is_data); end
        n_checks++; if (last_cmd !== 16'h0) begin n_fail++; $display("FAIL reset_last_cmd got %h want 0000", last_cmd); end
        n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0b/%0d want 0/0", overflow, drop_count); end
        n_checks++; if (bus.LCD_DATA_OE !== 1'b0 || bus.LCD_DATA_O !== 16'h0) begin n_fail++; $display("FAIL reset_bus got %0b/%h want 0/0000", bus.LCD_DATA_OE, bus.LCD_DATA_O); end
        #20 HRESETn = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
    endtask

    task automatic test_cmd_write;
        bus_write(1'b0, 1'b0, 16'h002C);
        repeat (2) @(posedge HCLK); #1;
        n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_latency_early got valid=%0b want 0", word_valid); end
        @(posedge HCLK); #1;
        n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL cmd_latency got valid=%0b want 1", word_valid); end
        n_checks++; if (word_is_data !== 1'b0 || word_data !== 16'h002C) begin n_fail++; $display("FAIL cmd_head got %0b/%h want 0/002c", word_is_data, word_data); end
        n_checks++; if (last_cmd !== 16'h002C) begin n_fail++; $display("FAIL cmd_last_cmd got %h want 002c", last_cmd); end
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL cmd_count got %0d want 1", fifo_count); end
        repeat (2) @(posedge HCLK); #1;
        word_ready = 1'b1;
        @(posedge HCLK); #1;
        word_ready = 1'b0;
        n_checks++; if (fifo_count !== 5'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_pop got count=%0d valid=%0b want 0/0", fifo_count, word_valid); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 17; i++) bus_write_settle(1'b0, 1'b1, 16'(i));
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drop_count got %0d want 1", drop_count); end
        for (int i = 1; i <= 16; i++) begin
            n_checks++;
            if (word_valid !== 1'b1 || word_is_data !== 1'b1 || word_data !== 16'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d got v=%0b d=%0b %h want 1/1 %h", i, word_valid, word_is_data, word_data, 16'(i));
            end
            word_ready = 1'b1;
            @(posedge HCLK); #1;
            word_ready = 1'b0;
        end
        n_checks++; if (word_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL drain_empty got valid=%0b count=%0d want 0/0", word_valid, fifo_count); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) bus_write_settle(1'b0, 1'b1, 16'h0021 + 16'(i));
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL b2b_fill got %0d want 16", fifo_count); end
        for (int k = 0; k < 2; k++) begin
            bus_write(1'b0, 1'b1, 16'h0100 + 16'(k));
            repeat (2) @(posedge HCLK); #1;
            word_ready = 1'b1;
            @(posedge HCLK); #1;
            word_ready = 1'b0;
            repeat (3) @(posedge HCLK); #1;
            n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL b2b_count_%0d got %0d want 16", k, fifo_count); end
        end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL b2b_drop got %0d want 1", drop_count); end
        n_checks++; if (word_data !== 16'h0023) begin n_fail++; $display("FAIL b2b_head got %h want 0023", word_data); end
        bus.LCD_RST = 1'b0;
        repeat (4) @(posedge HCLK); #1;
        bus.LCD_RST = 1'b1;
        repeat (4) @(posedge HCLK); #1;
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL b2b_flush got %0d want 0", fifo_count); end
    endtask

    task automatic test_read;
        bus.LCD_CS = 1'b0;
        rd_word    = 16'h9341;
        bus.LCD_RD = 1'b0;
        repeat (2) @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b0) begin n_fail++; $display("FAIL rd_oe_early got %0b want 0", bus.LCD_DATA_OE); end
        @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b1) begin n_fail++; $display("FAIL rd_oe_on got %0b want 1", bus.LCD_DATA_OE); end
        n_checks++; if (bus.LCD_DATA_O !== 16'h9341) begin n_fail++; $display("FAIL rd_data got %h want 9341", bus.LCD_DATA_O); end
        rd_word = 16'h0000;
        repeat (3) @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_O !== 16'h9341 || bus.LCD_DATA_OE !== 1'b1) begin n_fail++; $display("FAIL rd_hold got %h/%0b want 9341/1", bus.LCD_DATA_O, bus.LCD_DATA_OE); end
        bus.LCD_RD = 1'b1;
        repeat (2) @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b1) begin n_fail++; $display("FAIL rd_oe_late got %0b want 1", bus.LCD_DATA_OE); end
        @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b0 || bus.LCD_DATA_O !== 16'h9341) begin n_fail++; $display("FAIL rd_release got %0b/%h want 0/9341", bus.LCD_DATA_OE, bus.LCD_DATA_O); end
    endtask

    task automatic test_cs_and_panel_reset;
        bus_write_settle(1'b1, 1'b1, 16'h00AA);
        bus_write_settle(1'b1, 1'b0, 16'h00BB);
        n_checks++; if (fifo_count !== 5'd0 || last_cmd !== 16'h0) begin n_fail++; $display("FAIL cs_ignored got count=%0d last=%h want 0/0000", fifo_count, last_cmd); end
        bus_write_settle(1'b0, 1'b0, 16'h0029);
        bus_write_settle(1'b0, 1'b1, 16'h1111);
        bus_write_settle(1'b0, 1'b1, 16'h2222);
        n_checks++; if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL prst_queued got %0d want 3", fifo_count); end
        n_checks++; if (last_cmd !== 16'h0029 || word_is_data !== 1'b0 || word_data !== 16'h0029) begin n_fail++; $display("FAIL prst_head got last=%h %0b/%h want 0029 0/0029", last_cmd, word_is_data, word_data); end
        bus.LCD_RST = 1'b0;
        repeat (4) @(posedge HCLK); #1;
        n_checks++; if (fifo_count !== 5'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL prst_flush got count=%0d valid=%0b want 0/0", fifo_count, word_valid); end
        n_checks++; if (last_cmd !== 16'h0) begin n_fail++; $display("FAIL prst_last_cmd got %h want 0000", last_cmd); end
        n_checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin n_fail++; $display("FAIL prst_keep_drop got %0b/%0d want 1/1", overflow, drop_count); end
        bus.LCD_RST = 1'b1;
        repeat (4) @(posedge HCLK); #1;
    endtask

    task automatic test_hreset_mid_read;
        for (int i = 0; i < 5; i++) bus_write_settle(1'b0, 1'b1, 16'h0500 + 16'(i));
        n_checks++; if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL hrst_queued got %0d want 5", fifo_count); end
        rd_word    = 16'h5A5A;
        bus.LCD_RD = 1'b0;
        repeat (4) @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b1) begin n_fail++; $display("FAIL hrst_drive got %0b want 1", bus.LCD_DATA_OE); end
        #2 HRESETn = 1'b0;
        #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b0 || bus.LCD_DATA_O !== 16'h0) begin n_fail++; $display("FAIL hrst_bus got %0b/%h want 0/0000", bus.LCD_DATA_OE, bus.LCD_DATA_O); end
        n_checks++; if (fifo_count !== 5'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL hrst_fifo got count=%0d valid=%0b want 0/0", fifo_count, word_valid); end
        n_checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL hrst_drop got %0d/%0b want 0/0", drop_count, overflow); end
        bus.LCD_RD = 1'b1;
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        repeat (5) @(posedge HCLK); #1;
        n_checks++; if (bus.LCD_DATA_OE !== 1'b0) begin n_fail++; $display("FAIL hrst_after got %0b want 0", bus.LCD_DATA_OE); end
    endtask

    initial begin
        HRESETn        = 1'b0;
        bus.LCD_CS     = 1'b1;
        bus.LCD_RS     = 1'b0;
        bus.LCD_WR     = 1'b1;
        bus.LCD_RD     = 1'b1;
        bus.LCD_RST    = 1'b1;
        bus.LCD_DATA_I = 16'h0;
        rd_word        = 16'h0;
        word_ready     = 1'b0;

        test_reset();
        test_cmd_write();
        test_overflow();
        test_back_to_back();
        test_read();
        test_cs_and_panel_reset();
        test_hreset_mid_read();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
